// File: rtl/hit_cb_wr_rd_ctrl.sv
// hit_cb_wr_rd_ctrl: circular-buffer write/read controller with L1A-triggered reads into a small output FIFO
module hit_cb_wr_rd_ctrl #(
  parameter int WORDW   = 8,
  parameter int ADDRW   = 7,
  parameter int OFDEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [ADDRW-1:0]       latency,
  input  logic [WORDW-1:0]       hitIn,
  input  logic                   L1A,
  output logic                   ramCENB,
  output logic [ADDRW-1:0]       ramAB,
  output logic [WORDW-1:0]       ramDB,
  output logic                   ramCENA,
  output logic [ADDRW-1:0]       ramAA,
  input  logic [WORDW-1:0]       ramQA,
  output logic [ADDRW+WORDW-1:0] dout,
  output logic                   doutValid,
  input  logic                   doutReady,
  output logic [15:0]            trigDropCnt,
  output logic [1:0]             state
);
  localparam int PW = (OFDEPTH > 1) ? $clog2(OFDEPTH) : 1;
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2} st_t;
  st_t cur, nxt;
  logic [ADDRW-1:0] wr_ptr, fill_cnt, lat_l, rd_addr, rd_addr_d1;
  logic wr, acc, in_flight, pop;
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic [CW:0] occ;
  logic [ADDRW+WORDW-1:0] mem [OFDEPTH];
  always_comb begin
    nxt = !enable ? IDLE :
          cur == IDLE ? FILL :
          (cur == FILL && fill_cnt == lat_l - ADDRW'(1)) ? RUN : cur;
  end
  assign wr      = cur != IDLE;
  assign rd_addr = wr_ptr - lat_l;
  // a read issued last cycle still owns a FIFO slot until its data lands
  assign occ       = (CW+1)'(cnt) + (CW+1)'(in_flight);
  assign acc       = cur == RUN && enable && L1A && occ < (CW+1)'(OFDEPTH);
  assign doutValid = cnt != '0;
  assign pop       = doutValid && doutReady;
  assign dout      = mem[rp];
  assign ramCENB   = !wr;
  assign ramAB     = wr_ptr;
  assign ramDB     = hitIn;
  assign ramCENA   = !acc;
  assign ramAA     = acc ? rd_addr : '0;
  assign state     = cur;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur         <= IDLE;
      wr_ptr      <= '0;
      fill_cnt    <= '0;
      lat_l       <= ADDRW'(1);
      in_flight   <= 1'b0;
      rd_addr_d1  <= '0;
      wp          <= '0;
      rp          <= '0;
      cnt         <= '0;
      trigDropCnt <= '0;
      for (int i = 0; i < OFDEPTH; i++) mem[i] <= '0;
    end else begin
      cur <= nxt;
      if (cur == IDLE && enable) begin
        lat_l    <= (latency == '0) ? ADDRW'(1) : latency;
        fill_cnt <= '0;
      end else if (cur == FILL) fill_cnt <= fill_cnt + ADDRW'(1);
      if (wr) wr_ptr <= wr_ptr + ADDRW'(1);
      in_flight  <= acc;
      rd_addr_d1 <= rd_addr;
      if (in_flight) begin
        mem[wp] <= {rd_addr_d1, ramQA};
        wp      <= wp + PW'(1);
      end
      if (pop) rp <= rp + PW'(1);
      cnt <= cnt + CW'(in_flight) - CW'(pop);
      if (L1A && !acc && trigDropCnt != 16'hFFFF) trigDropCnt <= trigDropCnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_hit_cb_wr_rd_ctrl.sv
// tb_hit_cb_wr_rd_ctrl: directed bench with a RAM model and a dout scoreboard drained by a monitor
module tb_hit_cb_wr_rd_ctrl;
  logic clk = 0, reset, enable, L1A, doutReady;
  logic [6:0] latency, ramAB, ramAA;
  logic [7:0] hitIn, ramDB, ramQA;
  logic ramCENB, ramCENA, doutValid;
  logic [14:0] dout;
  logic [15:0] trigDropCnt;
  logic [1:0] state;
  logic [7:0] ram [128];
  logic [14:0] exp_q [$];
  logic [6:0] ptr, first_a;
  logic wrk;
  int total = 0, bad = 0;

  hit_cb_wr_rd_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable), .latency(latency), .hitIn(hitIn), .L1A(L1A),
    .ramCENB(ramCENB), .ramAB(ramAB), .ramDB(ramDB), .ramCENA(ramCENA), .ramAA(ramAA),
    .ramQA(ramQA), .dout(dout), .doutValid(doutValid), .doutReady(doutReady),
    .trigDropCnt(trigDropCnt), .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!ramCENB) ram[ramAB] <= ramDB;
    if (!ramCENA) ramQA <= ram[ramAA];
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && doutValid && doutReady) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dout_unexpected got=%0h exp=none", dout);
      end else chk("dout", {17'd0, dout}, {17'd0, exp_q.pop_front()});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (wrk) ptr = ptr + 7'd1;
    hitIn = {1'b0, ptr};
  endtask

  task automatic trig(input logic a_ok, input logic [6:0] a);
    L1A = 1;
    #1;
    chk("ramCENA", {31'd0, ramCENA}, {31'd0, !a_ok});
    if (a_ok) begin
      chk("ramAA", {25'd0, ramAA}, {25'd0, a});
      exp_q.push_back({a, 1'b0, a});
    end
    step();
    L1A = 0;
  endtask

  task automatic run_to(input logic [6:0] p);
    for (int i = 0; i < 200 && ptr != p; i++) step();
    chk("run_to_ptr", {25'd0, ptr}, {25'd0, p});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; enable = 0; L1A = 0; doutReady = 1; latency = 7'd10; hitIn = 0;
    ptr = 0; wrk = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {30'd0, state}, 0);
    chk("rst_cenb", {31'd0, ramCENB}, 1);
    chk("rst_cena", {31'd0, ramCENA}, 1);
    chk("rst_ab", {25'd0, ramAB}, 0);
    chk("rst_aa", {25'd0, ramAA}, 0);
    chk("rst_valid", {31'd0, doutValid}, 0);
    chk("rst_dout", {17'd0, dout}, 0);
    chk("rst_drop", {16'd0, trigDropCnt}, 0);
    reset = 0;
    // 1: latency 10, read at wrPtr 40 -> address 30, dout two clocks later
    enable = 1;
    step();
    wrk = 1;
    chk("t1_fill", {30'd0, state}, 1);
    repeat (10) step();
    chk("t1_run", {30'd0, state}, 2);
    chk("t1_ab", {25'd0, ramAB}, 10);
    chk("t1_cenb", {31'd0, ramCENB}, 0);
    run_to(7'd40);
    trig(1, 7'd30);
    chk("t1_valid_n1", {31'd0, doutValid}, 0);
    step();
    chk("t1_valid_n2", {31'd0, doutValid}, 1);
    chk("t1_dout", {17'd0, dout}, {17'd0, 7'd30, 8'd30});
    step();
    // 2: relatch latency 5, read wraps below zero
    enable = 0;
    step();
    wrk = 0;
    chk("t2_idle", {30'd0, state}, 0);
    latency = 7'd5; enable = 1;
    step();
    wrk = 1;
    repeat (300) step();
    run_to(7'd2);
    chk("t2_run", {30'd0, state}, 2);
    trig(1, 7'd125);
    repeat (3) step();
    // 3: back-pressure, four slots then two drops
    doutReady = 0;
    first_a = ptr - 7'd5;
    for (int i = 0; i < 6; i++) trig(i < 4, ptr - 7'd5);
    repeat (2) step();
    chk("t3_drop", {16'd0, trigDropCnt}, 2);
    chk("t3_valid", {31'd0, doutValid}, 1);
    chk("t3_hold", {17'd0, dout}, {17'd0, first_a, 1'b0, first_a});
    doutReady = 1;
    repeat (6) step();
    chk("t3_drained", exp_q.size(), 0);
    chk("t3_empty", {31'd0, doutValid}, 0);
    // 4: triggers while idle and while filling are dropped
    enable = 0;
    step();
    wrk = 0;
    trig(0, 7'd0);
    chk("t4_drop_idle", {16'd0, trigDropCnt}, 3);
    latency = 7'd0; enable = 1;
    step();
    wrk = 1;
    chk("t4_fill", {30'd0, state}, 1);
    trig(0, 7'd0);
    chk("t4_drop_fill", {16'd0, trigDropCnt}, 4);
    chk("t4_run", {30'd0, state}, 2);
    // 5: latency 0 acts as 1; later latency changes ignored
    run_to(7'd7);
    trig(1, 7'd6);
    latency = 7'd50;
    repeat (2) step();
    trig(1, ptr - 7'd1);
    repeat (3) step();
    // 6: reset with three entries queued
    doutReady = 0;
    for (int i = 0; i < 3; i++) trig(1, ptr - 7'd1);
    step();
    chk("t6_valid_pre", {31'd0, doutValid}, 1);
    reset = 1; enable = 0;
    #1;
    chk("t6_valid", {31'd0, doutValid}, 0);
    chk("t6_state", {30'd0, state}, 0);
    chk("t6_drop", {16'd0, trigDropCnt}, 0);
    chk("t6_cenb", {31'd0, ramCENB}, 1);
    exp_q.delete();
    step();
    reset = 0; ptr = 0; wrk = 0; latency = 7'd3; enable = 1; doutReady = 1;
    step();
    wrk = 1;
    chk("t6_ab", {25'd0, ramAB}, 0);
    repeat (3) step();
    chk("t6_run", {30'd0, state}, 2);
    run_to(7'd20);
    trig(1, 7'd17);
    repeat (4) step();
    chk("end_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
